// File: rtl/gen3_packet_assembler.sv
// Gen3 packet assembler: steers checked lane bytes into TLP and DLLP streams and packs each into OUT_BYTES words.
// Latency: input register + word register (byte at edge N visible after edge N+1); no backpressure, downstream always accepts.
module gen3_packet_assembler #(
    parameter int LANES     = 2,
    parameter int OUT_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid,
    input  logic [8*LANES-1:0]     data_in,
    input  logic [6*LANES-1:0]     type_in,
    output logic [8*OUT_BYTES-1:0] tlp_data,
    output logic [OUT_BYTES-1:0]   tlp_be,
    output logic                   tlp_valid,
    output logic                   tlp_sop,
    output logic                   tlp_eop,
    output logic                   tlp_err,
    output logic [8*OUT_BYTES-1:0] dllp_data,
    output logic [OUT_BYTES-1:0]   dllp_be,
    output logic                   dllp_valid,
    output logic                   dllp_sop,
    output logic                   dllp_eop,
    output logic                   dllp_err
);
    localparam int DEPTH = OUT_BYTES + LANES - 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IW    = $clog2(DEPTH);

    typedef enum logic {IDLE, INPKT} state_t;

    typedef struct packed {
        logic [7:0] dat;
        logic       start;
        logic       last;
        logic       err;
    } slot_t;

    logic                 in_vld;
    logic [8*LANES-1:0]   in_dat;
    logic [6*LANES-1:0]   in_typ;
    logic                 unused_typ;

    assign unused_typ = ^in_typ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_vld <= 1'b0;
            in_dat <= '0;
            in_typ <= '0;
        end else begin
            in_vld <= valid;
            in_dat <= data_in;
            in_typ <= type_in;
        end
    end

    // Stream 0 is TLP (STP bit 0, body bit 2); stream 1 is DLLP (SDP bit 1, body bit 3).
    for (genvar s = 0; s < 2; s++) begin : g_stream
        localparam int SB = s;
        localparam int BB = s + 2;

        state_t                 state, state_nxt;
        slot_t                  acc     [DEPTH];
        slot_t                  acc_nxt [DEPTH];
        logic [CW-1:0]          fill, fill_nxt;
        logic [8*OUT_BYTES-1:0] emit_dat, word_dat;
        logic [OUT_BYTES-1:0]   emit_be, word_be;
        logic                   emit_vld, emit_sop, emit_eop, emit_err;
        logic                   word_vld, word_sop, word_eop, word_err;

        always_comb begin
            slot_t work [DEPTH];
            int    cnt;
            int    take;
            logic  found;
            logic  err_w;
            state_nxt = state;
            work      = acc;
            cnt       = int'(fill);
            take      = 0;
            found     = 1'b0;
            err_w     = 1'b0;
            emit_vld  = 1'b0;
            emit_dat  = '0;
            emit_be   = '0;
            emit_sop  = 1'b0;
            emit_eop  = 1'b0;
            emit_err  = 1'b0;
            if (in_vld) begin
                for (int l = 0; l < LANES; l++) begin
                    if (!in_typ[6*l+5] && in_typ[6*l+SB]) begin
                        // A start inside a packet closes the old one as malformed at its tail byte.
                        if (state_nxt == INPKT && cnt > 0) begin
                            work[IW'(cnt-1)].last = 1'b1;
                            work[IW'(cnt-1)].err  = 1'b1;
                        end
                        if (cnt < DEPTH) begin
                            work[IW'(cnt)] = {in_dat[8*l +: 8], 1'b1, 1'b0, 1'b0};
                            cnt++;
                        end
                        state_nxt = INPKT;
                    end else if (!in_typ[6*l+5] && in_typ[6*l+BB] && state_nxt == INPKT) begin
                        if (cnt < DEPTH) begin
                            work[IW'(cnt)] = {in_dat[8*l +: 8], 1'b0, in_typ[6*l+4], 1'b0};
                            cnt++;
                        end
                        if (in_typ[6*l+4]) begin
                            state_nxt = IDLE;
                        end
                    end
                end
                for (int j = 0; j < OUT_BYTES; j++) begin
                    if (!found && j < cnt) begin
                        take  = j + 1;
                        found = work[j].last;
                        err_w = work[j].last & work[j].err;
                    end
                end
                if (found || cnt >= OUT_BYTES) begin
                    emit_vld = 1'b1;
                    emit_sop = work[0].start;
                    emit_eop = found;
                    emit_err = err_w;
                    for (int j = 0; j < OUT_BYTES; j++) begin
                        if (j < take) begin
                            emit_dat[8*j +: 8] = work[j].dat;
                            emit_be[j]         = 1'b1;
                        end
                    end
                end else begin
                    take = 0;
                end
            end
            for (int j = 0; j < DEPTH; j++) begin
                acc_nxt[j] = (j + take < DEPTH) ? work[IW'(j + take)] : '0;
            end
            fill_nxt = CW'(cnt - take);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state <= IDLE;
                fill  <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    acc[j] <= '0;
                end
                word_dat <= '0;
                word_be  <= '0;
                word_vld <= 1'b0;
                word_sop <= 1'b0;
                word_eop <= 1'b0;
                word_err <= 1'b0;
            end else begin
                state <= state_nxt;
                fill  <= fill_nxt;
                for (int j = 0; j < DEPTH; j++) begin
                    acc[j] <= acc_nxt[j];
                end
                word_dat <= emit_dat;
                word_be  <= emit_be;
                word_vld <= emit_vld;
                word_sop <= emit_sop;
                word_eop <= emit_eop;
                word_err <= emit_err;
            end
        end

        if (s == 0) begin : g_tlp
            assign tlp_data  = word_dat;
            assign tlp_be    = word_be;
            assign tlp_valid = word_vld;
            assign tlp_sop   = word_sop;
            assign tlp_eop   = word_eop;
            assign tlp_err   = word_err;
        end else begin : g_dllp
            assign dllp_data  = word_dat;
            assign dllp_be    = word_be;
            assign dllp_valid = word_vld;
            assign dllp_sop   = word_sop;
            assign dllp_eop   = word_eop;
            assign dllp_err   = word_err;
        end
    end
endmodule

// File: tb/tb_gen3_packet_assembler.sv
// Bench for gen3_packet_assembler: directed scenarios plus random packet streams against a packet-level word model.
module tb_gen3_packet_assembler;
    localparam logic [5:0] T_STP  = 6'b000001;
    localparam logic [5:0] T_SDP  = 6'b000010;
    localparam logic [5:0] T_TB   = 6'b000100;
    localparam logic [5:0] T_DB   = 6'b001000;
    localparam logic [5:0] T_LAST = 6'b010000;
    localparam logic [5:0] T_IDLE = 6'b100000;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  be;
        logic        sop;
        logic        eop;
        logic        err;
    } word_t;

    typedef struct packed {
        logic [7:0] b;
        logic [5:0] t;
    } lb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] data_in = '0;
    logic [11:0] type_in = '0;
    logic [31:0] tlp_data, dllp_data;
    logic [3:0]  tlp_be, dllp_be;
    logic        tlp_valid, tlp_sop, tlp_eop, tlp_err;
    logic        dllp_valid, dllp_sop, dllp_eop, dllp_err;
    logic [79:0] all_out;

    int    tests = 0;
    int    fails = 0;
    word_t tq[$];
    word_t dq[$];
    lb_t   feed[$];
    word_t tw, dw;

    gen3_packet_assembler #(.LANES(2), .OUT_BYTES(4)) dut (
        .clk(clk), .rst(rst), .valid(valid), .data_in(data_in), .type_in(type_in),
        .tlp_data(tlp_data), .tlp_be(tlp_be), .tlp_valid(tlp_valid),
        .tlp_sop(tlp_sop), .tlp_eop(tlp_eop), .tlp_err(tlp_err),
        .dllp_data(dllp_data), .dllp_be(dllp_be), .dllp_valid(dllp_valid),
        .dllp_sop(dllp_sop), .dllp_eop(dllp_eop), .dllp_err(dllp_err)
    );

    assign all_out = {tlp_data, tlp_be, tlp_valid, tlp_sop, tlp_eop, tlp_err,
                      dllp_data, dllp_be, dllp_valid, dllp_sop, dllp_eop, dllp_err};

    always #5 clk = ~clk;

    function automatic logic [31:0] bmask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) if (be[k]) m[8*k +: 8] = 8'hff;
        return m;
    endfunction

    // Scoreboard: every emitted word must match the next word the packet model predicts.
    always @(negedge clk) begin
        if (rst && tlp_valid) begin
            tests++;
            assert (tq.size() != 0) else begin
                fails++;
                $error("FAIL tlp_unexpected: got data=%h be=%b, required no word", tlp_data, tlp_be);
            end
            if (tq.size() != 0) begin
                tw = tq.pop_front();
                assert ({tlp_data & bmask(tw.be), tlp_be, tlp_sop, tlp_eop, tlp_err} === {tw.d, tw.be, tw.sop, tw.eop, tw.err}) else begin
                    fails++;
                    $error("FAIL tlp_word: got d=%h be=%b s/e/e=%b%b%b, required d=%h be=%b s/e/e=%b%b%b",
                           tlp_data, tlp_be, tlp_sop, tlp_eop, tlp_err, tw.d, tw.be, tw.sop, tw.eop, tw.err);
                end
            end
        end
        if (rst && dllp_valid) begin
            tests++;
            assert (dq.size() != 0) else begin
                fails++;
                $error("FAIL dllp_unexpected: got data=%h be=%b, required no word", dllp_data, dllp_be);
            end
            if (dq.size() != 0) begin
                dw = dq.pop_front();
                assert ({dllp_data & bmask(dw.be), dllp_be, dllp_sop, dllp_eop, dllp_err} === {dw.d, dw.be, dw.sop, dw.eop, dw.err}) else begin
                    fails++;
                    $error("FAIL dllp_word: got d=%h be=%b s/e/e=%b%b%b, required d=%h be=%b s/e/e=%b%b%b",
                           dllp_data, dllp_be, dllp_sop, dllp_eop, dllp_err, dw.d, dw.be, dw.sop, dw.eop, dw.err);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [15:0] d, input logic [11:0] t);
        valid   = v;
        data_in = d;
        type_in = t;
        @(posedge clk);
        #1;
    endtask

    task automatic feed_one();
        lb_t a, b;
        a = feed.pop_front();
        if (feed.size() != 0) b = feed.pop_front();
        else b = {8'h00, T_IDLE};
        cyc(1'b1, {b.b, a.b}, {b.t, a.t});
    endtask

    task automatic run_feed(input int hold_pct);
        while (feed.size() != 0) begin
            if (int'($urandom_range(99)) < hold_pct) cyc(1'b0, 16'($urandom), 12'($urandom));
            else feed_one();
        end
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0000, {T_IDLE, T_IDLE});
        for (int i = 0; i < 2; i++) cyc(1'b0, 16'h0000, 12'h000);
    endtask

    // Packet-level model: a packet of len bytes becomes ceil(len/4) words; truncated packets end with err.
    task automatic add_pkt(input bit dl, input int len, input bit tr);
        logic [7:0] by[$];
        word_t      w;
        lb_t        e;
        for (int i = 0; i < len; i++) begin
            e.b = 8'($urandom);
            if (i == 0) e.t = dl ? T_SDP : T_STP;
            else e.t = (dl ? T_DB : T_TB) | ((i == len - 1 && !tr) ? T_LAST : 6'b0);
            feed.push_back(e);
            by.push_back(e.b);
        end
        for (int s = 0; s < len; s += 4) begin
            w = '0;
            for (int k = 0; k < 4 && s + k < len; k++) begin
                w.d[8*k +: 8] = by[s+k];
                w.be[k]       = 1'b1;
            end
            w.sop = (s == 0);
            w.eop = (s + 4 >= len);
            w.err = w.eop && tr;
            if (dl) dq.push_back(w);
            else tq.push_back(w);
        end
    endtask

    initial begin
        int    plen, gap;
        bit    dl, tr, prev_tr, prev_dl;
        word_t w;
        lb_t   e;

        // Reset with random inputs, then release with valid low
        for (int i = 0; i < 4; i++) begin
            cyc(1'($urandom_range(1)), 16'($urandom), 12'($urandom));
            check("reset_outputs", all_out, 80'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 16'($urandom), 12'($urandom));
            check("release_no_valid", {78'd0, tlp_valid, dllp_valid}, 80'd0);
        end

        // 6-byte TLP A0..A5 with explicit latency checks
        w = '0; w.d = 32'hA3A2A1A0; w.be = 4'hf; w.sop = 1'b1; tq.push_back(w);
        w = '0; w.d = 32'h0000A5A4; w.be = 4'h3; w.eop = 1'b1; tq.push_back(w);
        cyc(1'b1, 16'hA1A0, {T_TB, T_STP});
        cyc(1'b1, 16'hA3A2, {T_TB, T_TB});
        check("tlp6_not_yet", {79'd0, tlp_valid}, 80'd0);
        cyc(1'b1, 16'hA5A4, {T_TB | T_LAST, T_TB});
        check("tlp6_word1", {68'd0, tlp_data, tlp_be, tlp_valid, tlp_sop, tlp_eop, tlp_err}, {68'd0, 32'hA3A2A1A0, 4'hf, 4'b1100});
        cyc(1'b0, 16'h0000, 12'h000);
        check("tlp6_word2", {68'd0, tlp_data & 32'h0000ffff, tlp_be, tlp_valid, tlp_sop, tlp_eop, tlp_err}, {68'd0, 32'h0000A5A4, 4'h3, 4'b1010});
        cyc(1'b0, 16'h0000, 12'h000);
        check("tlp6_done", {79'd0, tlp_valid}, 80'd0);

        // 8-byte DLLP, back-to-back TLPs, mid-packet STP, stray body byte
        add_pkt(1'b1, 8, 1'b0);
        run_feed(0);
        add_pkt(1'b0, 5, 1'b0);
        add_pkt(1'b0, 3, 1'b0);
        run_feed(0);
        add_pkt(1'b0, 3, 1'b1);
        add_pkt(1'b0, 4, 1'b0);
        run_feed(0);
        e.b = 8'h55; e.t = T_TB; feed.push_back(e);
        run_feed(0);
        flush();
        check("directed_drain", {48'd0, 16'(tq.size()), 16'(dq.size())}, 80'd0);

        // Hold: three valid-low cycles mid-packet
        add_pkt(1'b0, 6, 1'b0);
        feed_one();
        feed_one();
        cyc(1'b0, 16'($urandom), 12'($urandom));
        check("hold_pending_emit", {79'd0, tlp_valid}, 80'd1);
        cyc(1'b0, 16'($urandom), 12'($urandom));
        check("hold_no_emit1", {79'd0, tlp_valid}, 80'd0);
        cyc(1'b0, 16'($urandom), 12'($urandom));
        check("hold_no_emit2", {79'd0, tlp_valid}, 80'd0);
        run_feed(0);
        flush();

        // Mid-packet reset drops the partial packet, then a clean packet follows
        cyc(1'b1, 16'h1110, {T_TB, T_STP});
        cyc(1'b1, 16'h1312, {T_TB, T_TB});
        #2 rst = 1'b0;
        #1 check("midreset_async", all_out, 80'd0);
        cyc(1'b0, 16'h0000, 12'h000);
        check("midreset_held", all_out, 80'd0);
        rst = 1'b1;
        add_pkt(1'b0, 4, 1'b0);
        run_feed(0);
        flush();
        check("midreset_drain", {48'd0, 16'(tq.size()), 16'(dq.size())}, 80'd0);

        // Random packet stream with gaps, stray body bytes, truncations and holds
        prev_tr = 1'b0;
        prev_dl = 1'b0;
        for (int p = 0; p < 60; p++) begin
            dl   = prev_tr ? prev_dl : 1'($urandom_range(1));
            plen = int'($urandom_range(11, 2));
            tr   = (p < 59) && (plen % 4 != 0) && ($urandom_range(3) == 0);
            if (!prev_tr) begin
                gap = int'($urandom_range(2));
                for (int g = 0; g < gap; g++) begin
                    e.b = 8'($urandom);
                    if ($urandom_range(3) == 0) e.t = $urandom_range(1) ? T_TB : T_DB;
                    else e.t = T_IDLE;
                    feed.push_back(e);
                end
            end
            add_pkt(dl, plen, tr);
            prev_tr = tr;
            prev_dl = dl;
        end
        run_feed(15);
        flush();
        check("random_drain", {48'd0, 16'(tq.size()), 16'(dq.size())}, 80'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
